// File: rtl/sprite_pkg.sv
// Shared constants, types and helpers for the sprite move resolver.
package sprite_pkg;

    localparam int unsigned SPRITE_SIZE = 16;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned BOUND_W     = 11;
    localparam int unsigned CH_W        = 8;
    localparam int unsigned COLOR_W     = 3 * CH_W;
    localparam int unsigned DIR_W       = 4;
    localparam int unsigned EDGE_W      = 4;
`ifdef COLLISION_COUNT_EN
    localparam int unsigned COUNT_W     = 16;
`endif

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        MOVE,
        CLEAR
    } state_t;

    // Bit positions inside move_dir.
    localparam int unsigned DIR_UP    = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_RIGHT = 2;
    localparam int unsigned DIR_LEFT  = 3;

    localparam logic [DIR_W-1:0] DIR_UP_OH    = DIR_W'(1 << DIR_UP);
    localparam logic [DIR_W-1:0] DIR_DOWN_OH  = DIR_W'(1 << DIR_DOWN);
    localparam logic [DIR_W-1:0] DIR_RIGHT_OH = DIR_W'(1 << DIR_RIGHT);
    localparam logic [DIR_W-1:0] DIR_LEFT_OH  = DIR_W'(1 << DIR_LEFT);

    // Bit positions inside edge_blocked.
    localparam int unsigned EDGE_TOP    = 0;
    localparam int unsigned EDGE_BOTTOM = 1;
    localparam int unsigned EDGE_RIGHT  = 2;
    localparam int unsigned EDGE_LEFT   = 3;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    // |ch - wall| <= tol using a 9-bit signed difference (no wrap-around).
    function automatic logic chan_match(input logic [CH_W-1:0] ch,
                                        input logic [CH_W-1:0] wall,
                                        input logic [CH_W-1:0] tol);
        logic signed [CH_W:0] diff;
        diff = $signed({1'b0, ch}) - $signed({1'b0, wall});
        if (diff < 0) begin
            diff = -diff;
        end
        return diff <= $signed({1'b0, tol});
    endfunction

endpackage

// File: rtl/edge_color_match.sv
// Combinational wall-colour test for one sprite edge average.
module edge_color_match
    import sprite_pkg::*;
#(
    parameter logic [7:0] WALL_R = 8'd0,
    parameter logic [7:0] WALL_G = 8'd0,
    parameter logic [7:0] WALL_B = 8'd255,
    parameter logic [7:0] TOL    = 8'd16
) (
    input  logic [COLOR_W-1:0] avg,
    output logic               solid_c
);

    rgb_t px;

    // Edge is solid only when every channel is within tolerance of the wall.
    always_comb begin
        px      = rgb_t'(avg);
        solid_c = chan_match(px.r, WALL_R, TOL) &&
                  chan_match(px.g, WALL_G, TOL) &&
                  chan_match(px.b, WALL_B, TOL);
    end

endmodule

// File: rtl/sprite_move_resolver.sv
// Per-frame wall detection and one-step sprite movement.
// Optional macro COLLISION_COUNT_EN adds a saturating blocked_count output.
module sprite_move_resolver
    import sprite_pkg::*;
#(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned STEP     = 1,
    parameter int unsigned INIT_X   = 0,
    parameter int unsigned INIT_Y   = 0,
    parameter logic [7:0]  WALL_R   = 8'd0,
    parameter logic [7:0]  WALL_G   = 8'd0,
    parameter logic [7:0]  WALL_B   = 8'd255,
    parameter logic [7:0]  TOL      = 8'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_done,
    input  logic [COLOR_W-1:0] avg_top,
    input  logic [COLOR_W-1:0] avg_bottom,
    input  logic [COLOR_W-1:0] avg_left,
    input  logic [COLOR_W-1:0] avg_right,
    input  logic               move_valid,
    input  logic [DIR_W-1:0]   move_dir,
    output logic               move_ready,
    output logic               move_done,
    output logic               move_blocked,
    output logic [COORD_W-1:0] sp_x,
    output logic [COORD_W-1:0] sp_y,
    output logic [EDGE_W-1:0]  edge_blocked,
    output logic               stats_clear
`ifdef COLLISION_COUNT_EN
    ,
    output logic [COUNT_W-1:0] blocked_count
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic               pending;
    logic [DIR_W-1:0]   dir_q;
    logic [EDGE_W-1:0]  solid_c;
    logic               blocked_c;
    logic [COORD_W-1:0] x_nxt_c;
    logic [COORD_W-1:0] y_nxt_c;

    edge_color_match #(.WALL_R(WALL_R), .WALL_G(WALL_G), .WALL_B(WALL_B), .TOL(TOL))
        u_match_top    (.avg(avg_top),    .solid_c(solid_c[EDGE_TOP]));
    edge_color_match #(.WALL_R(WALL_R), .WALL_G(WALL_G), .WALL_B(WALL_B), .TOL(TOL))
        u_match_bottom (.avg(avg_bottom), .solid_c(solid_c[EDGE_BOTTOM]));
    edge_color_match #(.WALL_R(WALL_R), .WALL_G(WALL_G), .WALL_B(WALL_B), .TOL(TOL))
        u_match_right  (.avg(avg_right),  .solid_c(solid_c[EDGE_RIGHT]));
    edge_color_match #(.WALL_R(WALL_R), .WALL_G(WALL_G), .WALL_B(WALL_B), .TOL(TOL))
        u_match_left   (.avg(avg_left),   .solid_c(solid_c[EDGE_LEFT]));

    assign move_ready = !pending;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one frame walks EVAL -> MOVE -> CLEAR once.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_done) state_nxt = EVAL;
            EVAL:    state_nxt = MOVE;
            MOVE:    state_nxt = CLEAR;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Resolve the latched command against walls and screen bounds.
    always_comb begin
        blocked_c = 1'b1;
        x_nxt_c   = sp_x;
        y_nxt_c   = sp_y;
        case (dir_q)
            DIR_UP_OH: begin
                blocked_c = edge_blocked[EDGE_TOP] || (BOUND_W'(sp_y) < BOUND_W'(STEP));
                if (!blocked_c) y_nxt_c = sp_y - COORD_W'(STEP);
            end
            DIR_DOWN_OH: begin
                blocked_c = edge_blocked[EDGE_BOTTOM] ||
                            (BOUND_W'(sp_y) + BOUND_W'(SPRITE_SIZE) + BOUND_W'(STEP) > BOUND_W'(SCREEN_H));
                if (!blocked_c) y_nxt_c = sp_y + COORD_W'(STEP);
            end
            DIR_RIGHT_OH: begin
                blocked_c = edge_blocked[EDGE_RIGHT] ||
                            (BOUND_W'(sp_x) + BOUND_W'(SPRITE_SIZE) + BOUND_W'(STEP) > BOUND_W'(SCREEN_W));
                if (!blocked_c) x_nxt_c = sp_x + COORD_W'(STEP);
            end
            DIR_LEFT_OH: begin
                blocked_c = edge_blocked[EDGE_LEFT] || (BOUND_W'(sp_x) < BOUND_W'(STEP));
                if (!blocked_c) x_nxt_c = sp_x - COORD_W'(STEP);
            end
            default: blocked_c = 1'b1;
        endcase
    end

    // Datapath: edge flags, anchor, handshake and the CLEAR-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_x         <= COORD_W'(INIT_X);
            sp_y         <= COORD_W'(INIT_Y);
            edge_blocked <= '0;
            move_done    <= 1'b0;
            move_blocked <= 1'b0;
            stats_clear  <= 1'b0;
            pending      <= 1'b0;
            dir_q        <= '0;
        end else begin
            move_done    <= 1'b0;
            move_blocked <= 1'b0;
            stats_clear  <= 1'b0;
            if (state == EVAL) begin
                edge_blocked <= solid_c;
            end
            if (state == MOVE) begin
                stats_clear <= 1'b1;
                if (pending) begin
                    move_done    <= 1'b1;
                    move_blocked <= blocked_c;
                    sp_x         <= x_nxt_c;
                    sp_y         <= y_nxt_c;
                end
            end
            if (state == MOVE && pending) begin
                pending <= 1'b0;
            end else if (move_valid && !pending) begin
                pending <= 1'b1;
                dir_q   <= move_dir;
            end
        end
    end

`ifdef COLLISION_COUNT_EN
    // Saturating count of rejected commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            blocked_count <= '0;
        end else if (move_done && move_blocked && blocked_count != '1) begin
            blocked_count <= blocked_count + COUNT_W'(1);
        end
    end
`endif

endmodule
